io_in: RTL and testbench

// - Memory-mapped input device for the simulation test harness; counterpart of the output/power device.
// - Accepts a byte stream from the harness (stdin feeder) over valid/ready and buffers it in a FIFO.
// - Exposes it to the CPU as two read-only words selected by address[2]: DATA (pop) and STATUS.
// - Sits on the data bus beside the output device; the bus decoder drives read_enable.

---
 rtl/io_in_pkg.sv | 27 ++
 rtl/io_in_fifo.sv | 63 ++++++
 rtl/io_in.sv | 73 +++++++
 tb/tb_io_in.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/io_in_pkg.sv
// Shared definitions for the io_in input device: register select, empty-read marker
// and STATUS word layout.
package io_in_pkg;

    typedef enum logic {
        IO_IN_DATA   = 1'b0,
        IO_IN_STATUS = 1'b1
    } io_sel_e;

    localparam logic [31:0] IO_IN_EMPTY_WORD = 32'hFFFF_FFFF;

    localparam int unsigned IO_ST_AVAIL     = 0;
    localparam int unsigned IO_ST_EOF       = 1;
    localparam int unsigned IO_ST_COUNT_LSB = 8;

    function automatic logic [31:0] status_word(input logic [7:0] cnt,
                                                input logic       eof,
                                                input logic       avail);
        logic [31:0] w;
        w                          = '0;
        w[IO_ST_COUNT_LSB +: 8]    = cnt;
        w[IO_ST_EOF]               = eof;
        w[IO_ST_AVAIL]             = avail;
        return w;
    endfunction

endpackage

// File: rtl/io_in_fifo.sv
// Synchronous FIFO with combinational head output; push ignored when full,
// pop ignored when empty.
module io_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full && !reset;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/io_in.sv
// Memory-mapped input device: buffers harness bytes in a FIFO and exposes DATA (pop)
// and STATUS words through a registered read port.
module io_in
    import io_in_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_eof,
    input  logic        address,
    input  logic        read_enable,
    output logic [31:0] memory_out
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    io_sel_e       sel;
    logic [7:0]    head;
    logic [CW-1:0] count;
    logic          full, empty;
    logic          push, pop;
    logic          eof_seen_q, eof_seen_d;
    logic [31:0]   memory_out_q, memory_out_d;

    assign sel      = io_sel_e'(address);
    assign in_ready = !reset && !full;
    assign push     = in_valid && in_ready;
    assign pop      = read_enable && (sel == IO_IN_DATA) && !empty;

    io_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Read mux samples pre-edge FIFO state, so a same-edge push never bypasses to the reader.
    always_comb begin
        memory_out_d = memory_out_q;
        eof_seen_d   = eof_seen_q | in_eof;
        if (read_enable) begin
            if (sel == IO_IN_DATA)
                memory_out_d = empty ? IO_IN_EMPTY_WORD : {24'h0, head};
            else
                memory_out_d = status_word(8'(count), eof_seen_q, !empty);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            memory_out_q <= '0;
            eof_seen_q   <= 1'b0;
        end else begin
            memory_out_q <= memory_out_d;
            eof_seen_q   <= eof_seen_d;
        end
    end

    assign memory_out = memory_out_q;

endmodule

// File: tb/tb_io_in.sv
// Scoreboard bench for io_in: a byte-queue model predicts every read and in_ready.
module tb_io_in;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_eof;
    logic        address;
    logic        read_enable;
    logic [31:0] memory_out;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [7:0]  mq[$];
    logic [31:0] sb[$];
    logic        m_eof;
    logic [31:0] m_last;

    always #5 clk = ~clk;

    io_in #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_eof      (in_eof),
        .address     (address),
        .read_enable (read_enable),
        .memory_out  (memory_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: inputs applied #1 after an edge, outputs checked #1 after the next edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic re,
                         input logic a, input logic eof);
        logic        rdy;
        logic [31:0] e;
        in_valid = v; in_data = d; read_enable = re; address = a; in_eof = eof;
        rdy = (mq.size() != DEPTH);
        #1;
        chk("in_ready", {31'h0, in_ready}, {31'h0, rdy});
        if (re) begin
            if (!a) begin
                if (mq.size() != 0) e = {24'h0, mq.pop_front()};
                else                e = 32'hFFFF_FFFF;
            end else begin
                e = {16'h0, 8'(mq.size()), 6'h0, m_eof, (mq.size() != 0)};
            end
            sb.push_back(e);
        end
        if (v && rdy) mq.push_back(d);
        if (eof) m_eof = 1'b1;
        @(posedge clk); #1;
        if (re) begin
            m_last = sb.pop_front();
            chk(a ? "status" : "data", memory_out, m_last);
        end else begin
            chk("hold", memory_out, m_last);
        end
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic v);
        reset = 1'b1; in_valid = v; in_data = 8'hEE; read_enable = 1'b0;
        address = 1'b0; in_eof = 1'b0;
        #1;
        chk("ready_in_reset", {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        mq.delete(); sb.delete(); m_eof = 1'b0; m_last = '0;
        chk("reset_mem_out", memory_out, 32'h0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_eof = 1'b0;
        address = 1'b0; read_enable = 1'b0; m_eof = 1'b0; m_last = '0;
        @(posedge clk); #1;
        do_reset(1'b0);

        // 1: reset status
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("t1_status", memory_out, 32'h0);

        // 2: 'H','i'
        cycle(1'b1, 8'h48, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h69, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("t2_H", memory_out, 32'h48);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("t2_i", memory_out, 32'h69);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("t2_status", memory_out, 32'h0);

        // 3: fill to DEPTH with valid held, one extra attempt while full
        for (int i = 0; i < DEPTH + 1; i++)
            cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        chk("t3_ready_full", {31'h0, in_ready}, 32'h0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("t3_status", memory_out, 32'h0000_1001);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("t3_pop", memory_out, 32'h10);
        chk("t3_ready_after", {31'h0, in_ready}, 32'h1);

        // 5: refill, then full + valid + DATA read on the same edge
        cycle(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h21, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("t5_status", memory_out, 32'h0000_0F01);

        // 4: drain, empty read, then eof
        while (mq.size() != 0) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("t4_empty", memory_out, 32'hFFFF_FFFF);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("t4_eof", memory_out, 32'h0000_0002);

        // 6: push and read on an empty FIFO, no bypass
        cycle(1'b1, 8'h41, 1'b1, 1'b0, 1'b0);
        chk("t6_nobypass", memory_out, 32'hFFFF_FFFF);
        idle();
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("t6_data", memory_out, 32'h41);

        // random traffic, pointers wrap several times
        for (int i = 0; i < 300; i++)
            cycle(($urandom_range(0, 3) != 0), 8'($urandom),
                  ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 60) == 0));

        // 7: reset with 5 bytes buffered and a handshake in flight
        while (mq.size() != 0) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        do_reset(1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("t7_status", memory_out, 32'h0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("t7_empty", memory_out, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
